// File: rtl/data_island_assembler_if.sv
// Data island assembler bus.
// Groups the packet-level signals that pass between a packet source and the
// assembler.
//   data_island_period   : high on every pixel of a data island period
//   header               : packet header HB0..HB2, stable for a whole packet
//   sub                  : subpackets 0..3, stable for a whole packet
//   packet_pixel_counter : pixel index 0..31 within the current packet
//   packet_enable        : request for the next packet selection
//   packet_data          : TERC4 payload bits for the current pixel
// master = packet source / picker side, slave = assembler side.
interface data_island_assembler_if;
  logic             data_island_period;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [4:0]       packet_pixel_counter;
  logic             packet_enable;
  logic [8:0]       packet_data;

  modport master (
    output data_island_period,
    output header,
    output sub,
    input  packet_pixel_counter,
    input  packet_enable,
    input  packet_data
  );

  modport slave (
    input  data_island_period,
    input  header,
    input  sub,
    output packet_pixel_counter,
    output packet_enable,
    output packet_data
  );
endinterface

// File: rtl/data_island_assembler.sv
// Data island packet assembler.
// Walks a 32-pixel packet, serially computes the BCH ECC bytes for the header
// and the four subpackets while their data bits are being sent, and presents
// the ECC bytes in the trailing pixels of the packet.
// Ports:
//   clk_pixel : pixel clock, all state on its rising edge
//   reset_n   : asynchronous active-low reset
//   di        : assembler bus (slave side), see data_island_assembler_if
module data_island_assembler (
  input  logic                    clk_pixel,
  input  logic                    reset_n,
  data_island_assembler_if.slave  di
);

  logic [4:0]      counter;
  logic [7:0]      ecc_h;
  logic [3:0][7:0] ecc_s;
  logic            preload_done;

  logic            wrap;
  logic [5:0]      idx_lo;
  logic [5:0]      idx_hi;
  logic [31:0]     hx;
  logic [3:0][63:0] sx;
  logic [8:0]      packet_data_c;

  // One LSB-first serial step of the BCH(64,56)/(32,24) code,
  // generator 1 + x^6 + x^7 + x^8.
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    bch_step = (ecc >> 1) ^ ((ecc[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  assign wrap   = (counter == 5'd31);
  assign idx_lo = {counter, 1'b0};
  assign idx_hi = {counter, 1'b1};

  // Counter, ECC accumulators and the preload flag.
  // ECC is cleared on the wrap edge and while idle so that every packet's
  // parity covers only its own data bits.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= 5'd0;
      ecc_h        <= 8'h00;
      ecc_s        <= '0;
      preload_done <= 1'b0;
    end else begin
      counter      <= di.data_island_period ? counter + 5'd1 : 5'd0;
      // The preload request lasts only for the first idle pixel.
      preload_done <= !di.data_island_period;
      if (!di.data_island_period || wrap) begin
        ecc_h <= 8'h00;
        ecc_s <= '0;
      end else begin
        if (counter < 5'd24)
          ecc_h <= bch_step(ecc_h, di.header[counter]);
        if (counter < 5'd28) begin
          for (int n = 0; n < 4; n++)
            ecc_s[n] <= bch_step(bch_step(ecc_s[n], di.sub[n][idx_lo]), di.sub[n][idx_hi]);
        end
      end
    end
  end

  // Extended words: data in the low bits, the held ECC byte on top, so the
  // same bit selection serves both the data and the parity pixels.
  always_comb begin
    hx = {ecc_h, di.header};
    for (int n = 0; n < 4; n++)
      sx[n] = {ecc_s[n], di.sub[n]};
    packet_data_c = {sx[3][idx_hi], sx[2][idx_hi], sx[1][idx_hi], sx[0][idx_hi],
                     sx[3][idx_lo], sx[2][idx_lo], sx[1][idx_lo], sx[0][idx_lo],
                     hx[counter]};
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign di.packet_pixel_counter = counter;
  assign di.packet_data   = (reset_n && di.data_island_period) ? packet_data_c : 9'd0;
  assign di.packet_enable = reset_n && (di.data_island_period ? wrap : !preload_done);

endmodule

// File: tb/tb_data_island_assembler.sv
module tb_data_island_assembler;

  logic clk_pixel = 1'b0;
  logic reset_n;

  data_island_assembler_if dif();

  data_island_assembler dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .di        (dif.slave)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [23:0]      hdr;
    logic [3:0][55:0] sub;
    logic [7:0]       eh;
    logic [3:0][7:0]  es;
  } vec_t;

  typedef struct {
    logic [4:0] c;
    logic [8:0] data;
    logic       en;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference ECC: n bits of 'bits', LSB first.
  function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++)
      e = (e >> 1) ^ ((e[0] ^ bits[i]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  // Called just after a falling edge with the counter at 0. Drives the packet,
  // queues expectations for pixels 0..npix-1 and checks them as they appear.
  // Returns on a falling edge with the counter at npix (mod 32).
  task automatic run_packet(input vec_t v, input int npix, input string tag);
    logic [31:0]      hx;
    logic [3:0][63:0] sx;
    exp_t             e;
    exp_t             got;
    dif.header = v.hdr;
    dif.sub    = v.sub;
    dif.data_island_period = 1'b1;
    hx = {v.eh, v.hdr};
    for (int n = 0; n < 4; n++) sx[n] = {v.es[n], v.sub[n]};
    for (int c = 0; c < npix; c++) begin
      e.c    = 5'(c);
      e.data = {sx[3][2*c+1], sx[2][2*c+1], sx[1][2*c+1], sx[0][2*c+1],
                sx[3][2*c],   sx[2][2*c],   sx[1][2*c],   sx[0][2*c], hx[c]};
      e.en   = (c == 31);
      sb.push_back(e);
    end
    for (int c = 0; c < npix; c++) begin
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s scoreboard empty at pixel %0d", tag, c);
      end else begin
        got = sb.pop_front();
        chk($sformatf("%s counter c%0d", tag, c), 32'(dif.packet_pixel_counter), 32'(got.c));
        chk($sformatf("%s data c%0d", tag, c), 32'(dif.packet_data), 32'(got.data));
        chk($sformatf("%s enable c%0d", tag, c), 32'(dif.packet_enable), 32'(got.en));
      end
      @(negedge clk_pixel);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;

    // Vector table: fixed cases with known ECC, plus random ones.
    vecs[0] = '{hdr: 24'h0, sub: '0, eh: 8'h00, es: '0};
    vecs[1] = '{hdr: 24'h800000, sub: '0, eh: 8'h83, es: '0};
    vecs[2] = '{hdr: 24'h0, sub: '0, eh: 8'h00, es: '0};
    vecs[3] = '{hdr: 24'h0, sub: '0, eh: 8'h00, es: '0};
    vecs[3].sub[0] = 56'h80_0000_0000_0000;
    vecs[3].sub[1] = 56'h40_0000_0000_0000;
    vecs[3].es[0]  = 8'h83;
    vecs[3].es[1]  = 8'hC2;
    for (int k = 4; k < 6; k++) begin
      r = {$urandom, $urandom};
      vecs[k].hdr = r[23:0];
      vecs[k].eh  = bch({40'h0, r[23:0]}, 24);
      for (int n = 0; n < 4; n++) begin
        r = {$urandom, $urandom};
        vecs[k].sub[n] = r[55:0];
        vecs[k].es[n]  = bch({8'h0, r[55:0]}, 56);
      end
    end

    // Reset holds everything low even with an active, non-zero input.
    reset_n = 1'b0;
    dif.data_island_period = 1'b1;
    dif.header = 24'hFFFFFF;
    dif.sub    = '1;
    #3;
    chk("reset counter", 32'(dif.packet_pixel_counter), 32'd0);
    chk("reset data", 32'(dif.packet_data), 32'd0);
    chk("reset enable", 32'(dif.packet_enable), 32'd0);
    repeat (3) @(negedge clk_pixel);
    #1;
    chk("reset held counter", 32'(dif.packet_pixel_counter), 32'd0);
    chk("reset held data", 32'(dif.packet_data), 32'd0);

    // Release while idle: one-cycle preload request.
    dif.data_island_period = 1'b0;
    @(negedge clk_pixel);
    reset_n = 1'b1;
    #1;
    chk("preload enable", 32'(dif.packet_enable), 32'd1);
    chk("idle data", 32'(dif.packet_data), 32'd0);
    @(negedge clk_pixel);
    #1;
    chk("preload one cycle", 32'(dif.packet_enable), 32'd0);
    chk("idle counter", 32'(dif.packet_pixel_counter), 32'd0);
    @(negedge clk_pixel);

    // Table vectors applied back-to-back across wraps.
    for (int k = 0; k < 6; k++)
      run_packet(vecs[k], 32, $sformatf("vec%0d", k));

    dif.data_island_period = 1'b0;
    #1;
    chk("post packet data", 32'(dif.packet_data), 32'd0);
    chk("post packet preload", 32'(dif.packet_enable), 32'd1);
    @(negedge clk_pixel);
    #1;
    chk("post packet counter", 32'(dif.packet_pixel_counter), 32'd0);
    chk("post packet enable low", 32'(dif.packet_enable), 32'd0);
    @(negedge clk_pixel);

    // Period dropped at c=13, then a full packet recomputes ECC from scratch.
    run_packet(vecs[4], 13, "partial");
    dif.data_island_period = 1'b0;
    #1;
    chk("drop data", 32'(dif.packet_data), 32'd0);
    chk("drop enable", 32'(dif.packet_enable), 32'd1);
    @(negedge clk_pixel);
    #1;
    chk("drop counter cleared", 32'(dif.packet_pixel_counter), 32'd0);
    @(negedge clk_pixel);
    run_packet(vecs[1], 32, "restart");

    // Reset pulsed at c=20, released with the period still high.
    run_packet(vecs[3], 20, "pre_reset");
    reset_n = 1'b0;
    #1;
    chk("midreset counter", 32'(dif.packet_pixel_counter), 32'd0);
    chk("midreset data", 32'(dif.packet_data), 32'd0);
    chk("midreset enable", 32'(dif.packet_enable), 32'd0);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    run_packet(vecs[3], 32, "after_reset");

    dif.data_island_period = 1'b0;
    @(negedge clk_pixel);
    #1;
    chk("final counter", 32'(dif.packet_pixel_counter), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
